constraint_eval_seq: RTL
========================

# constraint_eval_seq

Parametrised, sequential successor to the single-term constraint checkers in the solver benchmark set. It accepts a bundle of NUM_TERMS (operand, constant, comparison-op) terms over a valid/ready handshake and evaluates them serially, one term per cycle. It returns the conjunction of all enabled terms, plus the index of the first failing term, over a second valid/ready handshake. It sits between the stimulus/operand source and the solver's result collector, and replaces one-off combinational `!=` checks with a single reusable engine.

## Interface
- WIDTH, 64, operand/constant width; narrower variables are zero-extended by the instantiator
- NUM_TERMS, 4, number of terms per bundle (≥1)
- EARLY_EXIT, 1, 1 = stop on the first failing enabled term; 0 = always walk all terms
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  bundle valid
- in_ready  out  1  engine can accept a bundle
- in_operands  in  NUM_TERMS*WIDTH  term i operand at [i*WIDTH +: WIDTH]
- in_consts  in  NUM_TERMS*WIDTH  term i constant, same packing
- in_ops  in  NUM_TERMS*3  term i opcode at [i*3 +: 3]
- in_mask  in  NUM_TERMS  1 = term enabled; a disabled term counts as satisfied
- out_valid  out  1  result valid
- out_ready  in  1  collector accepts result
- out_sat  out  1  1 = all enabled terms hold
- out_fail_idx  out  max(1,$clog2(NUM_TERMS))  index of the first failing term; 0 when out_sat=1

## Operation
- Opcodes, unsigned compare of operand against constant:
  - 0 NE, 1 EQ, 2 ULT, 3 ULE, 4 UGT, 5 UGE.
  - 6 NZ: operand != 0; the constant is ignored.
  - 7 reserved: always evaluates false.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&&in_ready, capture all inputs into registers, set idx=0 and acc=1, then go to EVAL.
- EVAL:
  - in_ready=0. Evaluate the term at idx.
  - If the term is enabled and false: set acc=0, set fail_idx=idx, and freeze fail_idx afterwards.
  - If EARLY_EXIT=1 and the term failed, go to DONE.
  - If idx==NUM_TERMS-1, go to DONE. Otherwise increment idx.
  - Masked terms still consume one cycle.
- DONE:
  - out_valid=1, out_sat=acc, out_fail_idx held.
  - When out_ready is high, go to IDLE.
  - Outputs stay stable until the handshake completes.
- Input bus changes after capture have no effect.
- If every term is masked, the result is out_sat=1 and out_fail_idx=0.

## Timing
- Reset values: state=IDLE, in_ready=1 once rst_n deasserts (0 while it is asserted), out_valid=0, out_sat=0, out_fail_idx=0, idx=0.
- Latency: with acceptance at edge E0, term k is evaluated at edge E(k+1).
  - out_valid is high in the cycle after E(NUM_TERMS), or after E(j+1) on an early exit at term j.
  - Minimum latency is 2 cycles: NUM_TERMS=1, or an early exit at term 0.
- Throughput: one bundle in flight at a time. A new bundle is accepted no earlier than the cycle after the out handshake; there is no same-cycle DONE→accept.
- out_ready asserted before out_valid has no effect.
- in_valid may drop without acceptance while in_ready=0; nothing is captured.
- rst_n asserted mid-EVAL or mid-DONE: the bundle is abandoned with no output. After release the engine is in IDLE with reset values.

## Structure
- Package constraint_pkg:
  - cmp_op_e enum with the 3-bit opcodes above.
  - eval_state_e enum (IDLE/EVAL/DONE).
  - Opcode constants shared with the generated split checkers.
- Sub-module constraint_cmp: combinational single-term evaluator with parameter WIDTH; inputs operand, const, op; output hold. It is instantiated once and muxed by idx.

## Test plan
- Single NE fail:
  - Stimulus: WIDTH=64, NUM_TERMS=4, term0 NE, operand=const=64'h18e69585ec5, all terms enabled, EARLY_EXIT=1.
  - Required: out_sat=0, out_fail_idx=0, out_valid in the 2nd cycle after acceptance.
- All pass:
  - Stimulus: term0 NE 0x18e69585ec4 vs 0x18e69585ec5; term1 ULT 3<5; term2 UGE 7>=7; term3 NZ 1.
  - Required: out_sat=1, out_fail_idx=0, latency 5 cycles.
- Full walk, first failure held:
  - Stimulus: EARLY_EXIT=0, terms 1 and 3 fail.
  - Required: out_fail_idx=1, out_sat=0, out_valid after E4.
- Mask and reserved opcode:
  - Stimulus: in_mask=4'b0000. Then a second bundle with in_mask=4'b0100 and term2 opcode 7.
  - Required: first bundle out_sat=1; second bundle out_sat=0 with out_fail_idx=2.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while changing input buses and asserting in_valid.
  - Required: outputs stable, in_ready=0, nothing captured. Then out_ready=1 → IDLE next cycle, and the new bundle is accepted the cycle after.
- Reset mid-EVAL:
  - Stimulus: assert rst_n=0 during term 2.
  - Required: out_valid=0 immediately (asynchronous). After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/constraint_pkg.sv
// Shared types and opcode constants for the serial constraint evaluator
// and the generated split checkers.
package constraint_pkg;

  localparam int CMP_OP_W = 3;

  typedef enum logic [CMP_OP_W-1:0] {
    CMP_NE   = 3'd0,
    CMP_EQ   = 3'd1,
    CMP_ULT  = 3'd2,
    CMP_ULE  = 3'd3,
    CMP_UGT  = 3'd4,
    CMP_UGE  = 3'd5,
    CMP_NZ   = 3'd6,
    CMP_RSVD = 3'd7
  } cmp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } eval_state_e;

  localparam logic [CMP_OP_W-1:0] OP_NE   = 3'd0;
  localparam logic [CMP_OP_W-1:0] OP_EQ   = 3'd1;
  localparam logic [CMP_OP_W-1:0] OP_ULT  = 3'd2;
  localparam logic [CMP_OP_W-1:0] OP_ULE  = 3'd3;
  localparam logic [CMP_OP_W-1:0] OP_UGT  = 3'd4;
  localparam logic [CMP_OP_W-1:0] OP_UGE  = 3'd5;
  localparam logic [CMP_OP_W-1:0] OP_NZ   = 3'd6;
  localparam logic [CMP_OP_W-1:0] OP_RSVD = 3'd7;

endpackage

// File: rtl/constraint_cmp.sv
// Combinational single-term evaluator: unsigned compare of operand against
// a constant. The reserved opcode never holds.
module constraint_cmp
  import constraint_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0]    operand,
  input  logic [WIDTH-1:0]    cmp_const,
  input  logic [CMP_OP_W-1:0] op,
  output logic                hold
);

  always_comb begin
    hold = 1'b0;
    case (cmp_op_e'(op))
      CMP_NE:  hold = (operand != cmp_const);
      CMP_EQ:  hold = (operand == cmp_const);
      CMP_ULT: hold = (operand <  cmp_const);
      CMP_ULE: hold = (operand <= cmp_const);
      CMP_UGT: hold = (operand >  cmp_const);
      CMP_UGE: hold = (operand >= cmp_const);
      CMP_NZ:  hold = (operand != '0);
      default: hold = 1'b0;
    endcase
  end

endmodule

// File: rtl/constraint_eval_seq.sv
// Serial constraint engine: captures a bundle of terms, evaluates one term
// per cycle, and returns the conjunction plus the first failing index.
module constraint_eval_seq
  import constraint_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int NUM_TERMS  = 4,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int IW        = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_TERMS*WIDTH-1:0]    in_operands,
  input  logic [NUM_TERMS*WIDTH-1:0]    in_consts,
  input  logic [NUM_TERMS*CMP_OP_W-1:0] in_ops,
  input  logic [NUM_TERMS-1:0]          in_mask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sat,
  output logic [IW-1:0]                 out_fail_idx,
  output eval_state_e                   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid-side data is held stable until that edge.

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TERMS - 1);

  eval_state_e                   state;
  logic [IW-1:0]                 idx;
  logic                          acc;
  logic [NUM_TERMS*WIDTH-1:0]    opnd_q;
  logic [NUM_TERMS*WIDTH-1:0]    const_q;
  logic [NUM_TERMS*CMP_OP_W-1:0] ops_q;
  logic [NUM_TERMS-1:0]          mask_q;

  logic [WIDTH-1:0]    cur_opnd;
  logic [WIDTH-1:0]    cur_const;
  logic [CMP_OP_W-1:0] cur_op;
  logic                cur_hold;
  logic                term_fail;
  logic                eval_done;

  assign cur_opnd  = opnd_q[int'(idx)*WIDTH +: WIDTH];
  assign cur_const = const_q[int'(idx)*WIDTH +: WIDTH];
  assign cur_op    = ops_q[int'(idx)*CMP_OP_W +: CMP_OP_W];

  constraint_cmp #(.WIDTH(WIDTH)) u_cmp (
    .operand   (cur_opnd),
    .cmp_const (cur_const),
    .op        (cur_op),
    .hold      (cur_hold)
  );

  assign term_fail = mask_q[idx] && !cur_hold;
  assign eval_done = (term_fail && EARLY_EXIT) || (idx == LAST_IDX);

  // Gated by rst_n so the engine never advertises readiness while held in reset.
  assign in_ready  = rst_n && (state == ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      acc          <= 1'b1;
      opnd_q       <= '0;
      const_q      <= '0;
      ops_q        <= '0;
      mask_q       <= '0;
      out_valid    <= 1'b0;
      out_sat      <= 1'b0;
      out_fail_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            opnd_q       <= in_operands;
            const_q      <= in_consts;
            ops_q        <= in_ops;
            mask_q       <= in_mask;
            idx          <= '0;
            acc          <= 1'b1;
            out_sat      <= 1'b0;
            out_fail_idx <= '0;
            state        <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (term_fail) begin
            acc <= 1'b0;
            // Only the first failure is recorded; acc still high means none yet.
            if (acc) out_fail_idx <= idx;
          end
          if (eval_done) begin
            out_valid <= 1'b1;
            out_sat   <= acc && !term_fail;
            state     <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
